serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit adder built around one 1-bit full-adder cell.
//  It accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake.
//  It adds them LSB-first, one bit per clock, through the cell.
//  It presents the WIDTH-bit sum and carry-out through a valid/ready handshake.
//  It is the sequential consumer of the full-adder cell and trades WIDTH cycles of latency for one cell of area.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range 1..32
// PORTS
//  clk        input   1      single clock, rising edge
//  rst_n      input   1      asynchronous active-low reset
//  in_valid   input   1      operands on a/b/cin are valid
//  in_ready   output  1      block can accept operands (IDLE only)
//  a          input   WIDTH  operand A
//  b          input   WIDTH  operand B
//  cin        input   1      carry-in
//  out_valid  output  1      sum/cout valid (DONE only)
//  out_ready  input   1      downstream accepts result
//  sum        output  WIDTH  a+b+cin, low WIDTH bits
//  cout       output  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  Clocking and reset
//  - One clock.
//  - Reset is asynchronous, active-low, and clears all state immediately.
//  - Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, count=0, carry=0.
//  State machine (IDLE, RUN, DONE)
//  - IDLE: in_ready=1. When in_valid&&in_ready at an edge:
//    - a_sr<=a, b_sr<=b, carry<=cin, count<=0, sum_sr<=0;
//    - go to RUN. a/b/cin are sampled only at this edge.
//  - RUN: in_ready=0, out_valid=0. Each edge:
//    - s=a_sr[0]^b_sr[0]^carry, produced by the cell;
//    - carry<=cell carry-out;
//    - a_sr,b_sr shift right by 1;
//    - sum_sr<={s,sum_sr[WIDTH-1:1]};
//    - count<=count+1.
//    - On the edge where count==WIDTH-1: go to DONE.
//  - DONE: out_valid=1, sum=sum_sr, cout=carry.
//    - sum/cout stay stable while out_valid&&!out_ready.
//    - On out_valid&&out_ready: go to IDLE.
//    - in_ready is not asserted in the same cycle, so there is one idle bubble between operations.
//  Latency and throughput
//  - Latency is WIDTH cycles: accept at edge k, out_valid high after edge k+WIDTH.
//  - Throughput: one result per WIDTH+2 cycles with out_ready held high.
//  Boundary conditions
//  - in_valid while RUN or DONE is ignored; operands are not queued.
//  - Arithmetic is modulo 2^WIDTH on sum; the overflow bit appears only on cout.
//  - WIDTH=1: RUN lasts exactly one cycle.
//  - count width is clog2(WIDTH)+1 and never wraps.
//  - rst_n low mid-RUN or mid-DONE aborts the operation:
//    - outputs return to reset values at once;
//    - the partial result is discarded;
//    - no out_valid pulse is produced after reset release.
//  - out_ready high while out_valid is low has no effect.
// STRUCTURE
//  - Shared package serial_add_pkg:
//    - state typedef/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//    - default WIDTH constant.
//  - One sub-module, fa_cell(a,b,ci,s,co): purely combinational full adder.
//    - s=a^b^ci; co=a&b | a&ci | b&ci.
//    - Instantiated once.
//  - Top level holds the FSM, shift registers, carry flop and counter.
// TESTING
//  1. Add, no overflow: a=8'h5A, b=8'h3C, cin=0, out_ready=1
//     -> out_valid 8 cycles after accept; sum=8'h96, cout=0.
//  2. Wrap to zero: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//     Max values: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  3. Backpressure: hold out_ready=0 for 5 cycles in DONE
//     -> out_valid, sum and cout stable throughout; in_ready=0;
//     -> release -> IDLE next edge.
//  4. Busy ignore: pulse in_valid with a=8'h11,b=8'h22 during RUN of an 8'h01+8'h02 op
//     -> result sum=8'h03; the second op is never accepted.
//  5. Reset mid-op: assert rst_n=0 at RUN count=3
//     -> in_ready=1 and out_valid=0 immediately;
//     -> no out_valid after release;
//     -> next op 8'h10+8'h20 gives sum=8'h30.
//  6. Exhaustive, WIDTH=1 and WIDTH=4: all a,b,cin combinations against a+b+cin reference;
//     check latency==WIDTH on every op.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM state encoding and the default operand width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder.
// The serial adder instantiates exactly one of these.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first
// through a single full-adder cell, one bit per clock.
module serial_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_shift;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_w, co_w;

  fa_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (s_w),
    .co (co_w)
  );

  // New sum bit enters at the MSB; a 1-bit sum is just the cell output.
  if (WIDTH == 1) begin : g_w1
    assign sum_shift = s_w;
  end else begin : g_wn
    assign sum_shift = {s_w, sum_sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): in_ready  = 1'b1;
      (state_q == ST_DONE): out_valid = 1'b1;
      default: ;
    endcase
    sum  = out_valid ? sum_sr_q : '0;
    cout = out_valid & carry_q;
  end

  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    if (state_q == ST_IDLE && in_valid) begin
      a_sr_d   = a;
      b_sr_d   = b;
      carry_d  = cin;
      cnt_d    = '0;
      sum_sr_d = '0;
    end else if (state_q == ST_RUN) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      sum_sr_d = sum_shift;
      carry_d  = co_w;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 4 and 1.
// Drivers push expected results; one monitor pops and compares.
module tb_serial_adder;

  typedef struct {
    logic [32:0] exp;
    int          acc;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  sb_t q8[$];
  sb_t q4[$];
  sb_t q1[$];

  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       cin8 = 0, iv8 = 0, ir8, ov8, or8 = 1, co8;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       cin4 = 0, iv4 = 0, ir4, ov4, or4 = 1, co4;
  logic [0:0] a1 = '0, b1 = '0, s1;
  logic       cin1 = 0, iv1 = 0, ir1, ov1, or1 = 1, co1;
  logic       ov8_p = 0, ov4_p = 0, ov1_p = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(co8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .out_ready(or4),
    .sum(s4), .cout(co4)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(co1)
  );

  // Monitor: latency on rising out_valid, value on handshake.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (ov8 && !ov8_p) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL unexpected8: out_valid=1 sum=%h want no output", s8);
        end else if (cyc - q8[0].acc != 8) begin
          errors++;
          $display("FAIL latency8: got %0d want 8", cyc - q8[0].acc);
        end
      end
      if (ov8 && or8 && q8.size() > 0) begin
        e = q8.pop_front();
        checks++;
        if ({co8, s8} !== e.exp[8:0]) begin
          errors++;
          $display("FAIL result8: got %h want %h", {co8, s8}, e.exp[8:0]);
        end
      end
      if (ov4 && !ov4_p) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL unexpected4: out_valid=1 sum=%h want no output", s4);
        end else if (cyc - q4[0].acc != 4) begin
          errors++;
          $display("FAIL latency4: got %0d want 4", cyc - q4[0].acc);
        end
      end
      if (ov4 && or4 && q4.size() > 0) begin
        e = q4.pop_front();
        checks++;
        if ({co4, s4} !== e.exp[4:0]) begin
          errors++;
          $display("FAIL result4: got %h want %h", {co4, s4}, e.exp[4:0]);
        end
      end
      if (ov1 && !ov1_p) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL unexpected1: out_valid=1 sum=%h want no output", s1);
        end else if (cyc - q1[0].acc != 1) begin
          errors++;
          $display("FAIL latency1: got %0d want 1", cyc - q1[0].acc);
        end
      end
      if (ov1 && or1 && q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if ({co1, s1} !== e.exp[1:0]) begin
          errors++;
          $display("FAIL result1: got %h want %h", {co1, s1}, e.exp[1:0]);
        end
      end
    end
    ov8_p = ov8;
    ov4_p = ov4;
    ov1_p = ov1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [32:0] act,
                     input logic [32:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [8:0] e);
    int n = 0;
    a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
    while (!ir8 && n < 100) begin step(); n++; end
    if (!ir8) begin
      chk("issue8_timeout", 33'(ir8), 33'd1);
      iv8 = 1'b0;
      return;
    end
    step();
    q8.push_back('{exp: 33'(e), acc: cyc});
    iv8 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [4:0] e);
    int n = 0;
    a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
    while (!ir4 && n < 100) begin step(); n++; end
    if (!ir4) begin
      chk("issue4_timeout", 33'(ir4), 33'd1);
      iv4 = 1'b0;
      return;
    end
    step();
    q4.push_back('{exp: 33'(e), acc: cyc});
    iv4 = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b,
                        input logic c, input logic [1:0] e);
    int n = 0;
    a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
    while (!ir1 && n < 100) begin step(); n++; end
    if (!ir1) begin
      chk("issue1_timeout", 33'(ir1), 33'd1);
      iv1 = 1'b0;
      return;
    end
    step();
    q1.push_back('{exp: 33'(e), acc: cyc});
    iv1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() + q4.size() + q1.size() != 0 || !ir8 || !ir4 || !ir1)
           && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", 33'(n < 200), 33'd1);
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk("rst_in_ready", 33'({ir8, ir4, ir1}), 33'b111);
    chk("rst_out_valid", 33'({ov8, ov4, ov1}), 33'b000);
    chk("rst_sum8", 33'({co8, s8}), 33'h0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready8", 33'(ir8), 33'd1);

    // 1. simple add
    issue8(8'h5A, 8'h3C, 1'b0, 9'h096);
    drain();
    // 2. wrap and max
    issue8(8'hFF, 8'h01, 1'b0, 9'h100);
    issue8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    drain();

    // 3. backpressure
    or8 = 1'b0;
    issue8(8'hC3, 8'h3C, 1'b1, 9'h100);
    n = 0;
    while (!ov8 && n < 50) begin step(); n++; end
    chk("bp_reach_done", 33'(ov8), 33'd1);
    repeat (5) begin
      chk("bp_out_valid", 33'(ov8), 33'd1);
      chk("bp_sum", 33'({co8, s8}), 33'h100);
      chk("bp_in_ready", 33'(ir8), 33'd0);
      step();
    end
    or8 = 1'b1;
    step();
    chk("bp_release_idle", 33'({ir8, ov8}), 33'b10);
    drain();

    // 4. busy ignore
    issue8(8'h01, 8'h02, 1'b0, 9'h003);
    step();
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; iv8 = 1'b1;
    chk("busy_in_ready", 33'(ir8), 33'd0);
    step();
    iv8 = 1'b0;
    drain();
    repeat (12) step();

    // 5. reset mid-op at count=3
    issue8(8'h77, 8'h11, 1'b0, 9'h088);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 33'(ir8), 33'd1);
    chk("abort_out_valid", 33'(ov8), 33'd0);
    chk("abort_sum", 33'({co8, s8}), 33'h0);
    q8.delete();
    step();
    rst_n = 1'b1;
    repeat (12) step();
    issue8(8'h10, 8'h20, 1'b0, 9'h030);
    drain();

    // 6. exhaustive small widths
    for (int ia = 0; ia < 2; ia++)
      for (int ib = 0; ib < 2; ib++)
        for (int ic = 0; ic < 2; ic++)
          issue1(1'(ia), 1'(ib), 1'(ic), 2'(ia + ib + ic));
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          issue4(4'(ia), 4'(ib), 1'(ic), 5'(ia + ib + ic));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
